// File: rtl/matrix_pu.sv
// Matrix processing unit: computes one element C[i][j] of C = A x B as a dot
// product, reading A and B from shared memory under a grant handshake and
// writing the result back before pulsing result-ready.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for an index pair; range check on acceptance
// REQ      | bus requested, waiting for grant (also the re-entry after loss)
// FETCH_A  | address A[i][k] on the bus
// FETCH_B  | address B[k][j] on the bus, capture A[i][k]
// MAC      | B[k][j] on read data, accumulate, advance k
// WRITE    | write accumulator to C[i][j]

module matrix_pu #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Indexes_Ready,
    input  logic [INDEX_WIDTH-1:0] i_Row_Index,
    input  logic [INDEX_WIDTH-1:0] i_Column_Index,
    input  logic [31:0]            i_Config,
    output logic                   o_Indexes_Received,
    output logic                   o_Result_Ready,
    output logic                   o_Index_Error,
    output logic                   o_Grant_Request,
    input  logic                   i_Grant,
    output logic [ADDR_WIDTH-1:0]  o_Memory_Address,
    input  logic [DATA_WIDTH-1:0]  i_Memory_Data,
    output logic [DATA_WIDTH-1:0]  o_Memory_Data,
    output logic                   o_Write_Enable
);

    // Common compare width for indices and 8-bit dimension fields.
    localparam int CW = (INDEX_WIDTH > 8) ? INDEX_WIDTH : 8;
    // Wide enough that address arithmetic never overflows before truncation.
    localparam int PW = 2 * CW + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FETCH_A,
        S_FETCH_B,
        S_MAC,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [7:0]            r_m;
    logic [7:0]            r_kdim;
    logic [7:0]            r_n;
    logic [CW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_k;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_idx_rcvd;
    logic                  r_result_ready;
    logic                  r_index_error;

    logic                  w_in_range;
    logic                  w_k_more;
    logic                  w_k_inc_more;
    logic [CW:0]           w_k_inc;
    logic [DATA_WIDTH-1:0] w_product;
    logic [PW-1:0]         w_b_base;
    logic [PW-1:0]         w_c_base;
    logic [PW-1:0]         w_addr_a;
    logic [PW-1:0]         w_addr_b;
    logic [PW-1:0]         w_addr_c;
    logic                  w_unused_k_copy;

    // The duplicate K field carries no information for this unit.
    assign w_unused_k_copy = ^i_Config[23:16];

    assign w_in_range = (CW'(i_Row_Index)    < CW'(i_Config[7:0])) &&
                        (CW'(i_Column_Index) < CW'(i_Config[31:24]));

    assign w_k_inc      = {1'b0, r_k} + 1'b1;
    assign w_k_more     = (r_k < CW'(r_kdim));
    assign w_k_inc_more = (w_k_inc < (CW + 1)'(r_kdim));

    // Low bits of a product are the same for signed and unsigned operands,
    // so a plain truncated multiply gives the wrapped signed result.
    assign w_product = r_a * i_Memory_Data;

    assign w_b_base = PW'(1) + PW'(r_m) * PW'(r_kdim);
    assign w_c_base = w_b_base + PW'(r_kdim) * PW'(r_n);
    assign w_addr_a = PW'(1) + PW'(r_row) * PW'(r_kdim) + PW'(r_k);
    assign w_addr_b = w_b_base + PW'(r_k) * PW'(r_n) + PW'(r_col);
    assign w_addr_c = w_c_base + PW'(r_row) * PW'(r_n) + PW'(r_col);

    // State register plus datapath registers and registered status pulses.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state        <= S_IDLE;
            r_m            <= '0;
            r_kdim         <= '0;
            r_n            <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_k            <= '0;
            r_a            <= '0;
            r_acc          <= '0;
            r_idx_rcvd     <= 1'b0;
            r_result_ready <= 1'b0;
            r_index_error  <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_idx_rcvd     <= 1'b0;
            r_result_ready <= 1'b0;
            r_index_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_Indexes_Ready) begin
                        r_m        <= i_Config[7:0];
                        r_kdim     <= i_Config[15:8];
                        r_n        <= i_Config[31:24];
                        r_row      <= CW'(i_Row_Index);
                        r_col      <= CW'(i_Column_Index);
                        r_idx_rcvd <= 1'b1;
                        r_k        <= '0;
                        r_acc      <= '0;
                        if (!w_in_range) begin
                            r_index_error  <= 1'b1;
                            r_result_ready <= 1'b1;
                        end
                    end
                end
                S_FETCH_B: begin
                    if (i_Grant) begin
                        r_a <= i_Memory_Data;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_product;
                    r_k   <= w_k_inc[CW-1:0];
                end
                S_WRITE: begin
                    if (i_Grant) begin
                        r_result_ready <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and bus decode; a lost grant voids the cycle and falls back to REQ.
    always_comb begin
        w_state_next     = r_state;
        o_Grant_Request  = 1'b0;
        o_Memory_Address = '0;
        o_Memory_Data    = '0;
        o_Write_Enable   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Indexes_Ready && w_in_range) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                o_Grant_Request = 1'b1;
                if (i_Grant) begin
                    w_state_next = w_k_more ? S_FETCH_A : S_WRITE;
                end
            end
            S_FETCH_A: begin
                o_Grant_Request  = 1'b1;
                o_Memory_Address = ADDR_WIDTH'(w_addr_a);
                w_state_next     = i_Grant ? S_FETCH_B : S_REQ;
            end
            S_FETCH_B: begin
                o_Grant_Request  = 1'b1;
                o_Memory_Address = ADDR_WIDTH'(w_addr_b);
                w_state_next     = i_Grant ? S_MAC : S_REQ;
            end
            S_MAC: begin
                o_Grant_Request = 1'b1;
                w_state_next    = w_k_inc_more ? S_FETCH_A : S_WRITE;
            end
            S_WRITE: begin
                o_Grant_Request  = 1'b1;
                o_Memory_Address = ADDR_WIDTH'(w_addr_c);
                o_Memory_Data    = r_acc;
                o_Write_Enable   = i_Grant;
                w_state_next     = i_Grant ? S_IDLE : S_REQ;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_Indexes_Received = r_idx_rcvd;
    assign o_Result_Ready     = r_result_ready;
    assign o_Index_Error      = r_index_error;

endmodule

// File: tb/tb_matrix_pu.sv
// Directed bench for matrix_pu with a memory model and a write scoreboard.
// Cycle numbering: the cycle right after the acceptance edge is cycle 1.

module tb_matrix_pu;

    logic        clk = 1'b0;
    logic        i_Reset;
    logic        i_Indexes_Ready;
    logic [7:0]  i_Row_Index;
    logic [7:0]  i_Column_Index;
    logic [31:0] i_Config;
    logic        o_Indexes_Received;
    logic        o_Result_Ready;
    logic        o_Index_Error;
    logic        o_Grant_Request;
    logic        i_Grant;
    logic [9:0]  o_Memory_Address;
    logic [31:0] i_Memory_Data;
    logic [31:0] o_Memory_Data;
    logic        o_Write_Enable;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_writes = 0;

    always #5 clk = ~clk;

    matrix_pu #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .INDEX_WIDTH(8)) dut (
        .i_Clock            (clk),
        .i_Reset            (i_Reset),
        .i_Indexes_Ready    (i_Indexes_Ready),
        .i_Row_Index        (i_Row_Index),
        .i_Column_Index     (i_Column_Index),
        .i_Config           (i_Config),
        .o_Indexes_Received (o_Indexes_Received),
        .o_Result_Ready     (o_Result_Ready),
        .o_Index_Error      (o_Index_Error),
        .o_Grant_Request    (o_Grant_Request),
        .i_Grant            (i_Grant),
        .o_Memory_Address   (o_Memory_Address),
        .i_Memory_Data      (i_Memory_Data),
        .o_Memory_Data      (o_Memory_Data),
        .o_Write_Enable     (o_Write_Enable)
    );

    // Registered read port: data for an address arrives the next cycle.
    always @(posedge clk) begin
        i_Memory_Data <= mem[o_Memory_Address];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (!i_Reset && o_Write_Enable) begin
            n_writes++;
            check("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(o_Memory_Address), 64'(e.addr));
                check("wr_data", 64'(o_Memory_Data), 64'(e.data));
            end
        end
    end

    task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic accept(input logic [31:0] cfg, input logic [7:0] r, input logic [7:0] c);
        i_Config        = cfg;
        i_Row_Index     = r;
        i_Column_Index  = c;
        i_Indexes_Ready = 1'b1;
        @(negedge clk);
        i_Indexes_Ready = 1'b0;
    endtask

    task automatic wait_rr(input int limit, inout int cyc);
        while (!o_Result_Ready && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},  64'(o_Grant_Request),    64'd0);
        check({tag, "_we"},   64'(o_Write_Enable),     64'd0);
        check({tag, "_addr"}, 64'(o_Memory_Address),   64'd0);
        check({tag, "_data"}, 64'(o_Memory_Data),      64'd0);
        check({tag, "_rcvd"}, 64'(o_Indexes_Received), 64'd0);
        check({tag, "_rr"},   64'(o_Result_Ready),     64'd0);
        check({tag, "_err"},  64'(o_Index_Error),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_rcvd;
        int n_rr;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        i_Reset         = 1'b1;
        i_Indexes_Ready = 1'b0;
        i_Row_Index     = 8'd0;
        i_Column_Index  = 8'd0;
        i_Config        = 32'h03030303;
        i_Grant         = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        i_Reset = 1'b0;
        @(negedge clk);

        // 3x3: A = 1..9, B = identity, C[1][2] = 6 at address 19+3+2
        mem[0] = 32'h03030303;
        for (int i = 0; i < 9; i++) mem[1 + i] = 32'(i + 1);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                mem[10 + 3 * k + j] = (k == j) ? 32'd1 : 32'd0;
        push_wr(10'd24, 32'd6);
        accept(32'h03030303, 8'd1, 8'd2);
        check("t1_rcvd", 64'(o_Indexes_Received), 64'd1);
        check("t1_err",  64'(o_Index_Error),      64'd0);
        check("t1_rr0",  64'(o_Result_Ready),     64'd0);
        cyc = 1;
        wait_rr(60, cyc);
        check("t1_latency", 64'(cyc), 64'd12);
        @(negedge clk);
        check("t1_rr_pulse", 64'(o_Result_Ready),  64'd0);
        check("t1_req_off",  64'(o_Grant_Request), 64'd0);

        // B = all 2, C[2][0] = 2*(7+8+9) = 48 at 25; grant lost on second FETCH_B (addr 13)
        for (int i = 10; i < 19; i++) mem[i] = 32'd2;
        push_wr(10'd25, 32'd48);
        accept(32'h03030303, 8'd2, 8'd0);
        cyc = 1;
        while (o_Memory_Address != 10'd13 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("t2_fb_addr",  64'(o_Memory_Address), 64'd13);
        check("t2_fb_cycle", 64'(cyc), 64'd6);
        i_Grant = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            cyc++;
            check("t2_stall_req",  64'(o_Grant_Request), 64'd1);
            check("t2_stall_addr", 64'(o_Memory_Address), 64'd0);
        end
        i_Grant = 1'b1;
        wait_rr(80, cyc);
        check("t2_latency", 64'(cyc), 64'd17);

        // Out-of-range row: acceptance, error and result in the same cycle
        @(negedge clk);
        accept(32'h03030303, 8'd3, 8'd0);
        check("t3_rcvd", 64'(o_Indexes_Received), 64'd1);
        check("t3_err",  64'(o_Index_Error),      64'd1);
        check("t3_rr",   64'(o_Result_Ready),     64'd1);
        check("t3_req",  64'(o_Grant_Request),    64'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("t3_req_idle", 64'(o_Grant_Request), 64'd0);
            check("t3_err_once", 64'(o_Index_Error),   64'd0);
        end

        // K = 0: REQ then WRITE of 0 at C base 1
        push_wr(10'd1, 32'd0);
        accept(32'h03000003, 8'd0, 8'd0);
        check("t4_rcvd", 64'(o_Indexes_Received), 64'd1);
        check("t4_req",  64'(o_Grant_Request),    64'd1);
        @(negedge clk);
        cyc = 2;
        check("t4_we",   64'(o_Write_Enable),   64'd1);
        check("t4_addr", 64'(o_Memory_Address), 64'd1);
        wait_rr(20, cyc);
        check("t4_latency", 64'(cyc), 64'd3);
        @(negedge clk);

        // Reset during MAC of k=0 (cycle 4): aborted, never written
        accept(32'h03030303, 8'd1, 8'd1);
        repeat (3) @(negedge clk);
        check("t5_busy_req", 64'(o_Grant_Request), 64'd1);
        i_Reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("t5_abort");
        i_Reset = 1'b0;
        n_rr = 0;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            n_rr += int'(o_Result_Ready);
        end
        check("t5_no_result", 64'(n_rr), 64'd0);

        // 1x1x1 with ready held high: 0x7FFFFFFF * 2 = 0xFFFFFFFE at C base 3
        mem[1] = 32'h7FFFFFFF;
        mem[2] = 32'd2;
        push_wr(10'd3, 32'hFFFFFFFE);
        push_wr(10'd3, 32'hFFFFFFFE);
        accept(32'h01010101, 8'd0, 8'd0);
        i_Indexes_Ready = 1'b1;
        n_rcvd = int'(o_Indexes_Received);
        n_rr   = int'(o_Result_Ready);
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            n_rcvd += int'(o_Indexes_Received);
            n_rr   += int'(o_Result_Ready);
            if (c == 6) check("t6_latency", 64'(o_Result_Ready), 64'd1);
            if (c == 7) check("t6_reaccept", 64'(o_Indexes_Received), 64'd1);
        end
        i_Indexes_Ready = 1'b0;
        check("t6_rcvd_count", 64'(n_rcvd), 64'd2);
        check("t6_rr_count",   64'(n_rr),   64'd2);
        @(negedge clk);
        check("t6_no_third", 64'(o_Indexes_Received), 64'd0);
        repeat (5) @(negedge clk);

        check("sb_drained",  64'(exp_q.size()), 64'd0);
        check("write_count", 64'(n_writes),     64'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
